// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 single-bit mux between four
//   requesters. It grants one owner at a time and drives the mux select for
//   that owner. The owner keeps the grant until it releases it, and then the
//   arbiter re-arbitrates.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When this macro is defined, a grant is forcibly released after TIMEOUT
//   cycles and tmo pulses for one cycle. When it is undefined, tmo is tied to 0.
//
// Parameters
//   TIMEOUT  maximum grant length in cycles (2..255). Used only with ARB_TIMEOUT_EN.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high
//   req   in   [3:0] level-sensitive request lines, one per requester
//   done  in   release strobe from the current owner (looked at only in GRANT)
//   gnt   out  [3:0] registered one-hot grant, zero when there is no owner
//   sel   out  [1:0] registered mux select, index of the granted requester
//   busy  out  high while a grant is held
//   tmo   out  one-cycle pulse on forced (timeout) release
module mux4_rr_arbiter #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       tmo
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mux4_rr_arbiter: TIMEOUT must be in 2..255");
   end

   typedef enum logic [0:0] {IDLE, GRANT} state_t;

   state_t     state;
   logic [1:0] last_owner;
   logic [1:0] winner;
   logic       any_req;
   logic       owner_release;

   // Rotating priority search: last+1, last+2, last+3, last (all mod 4).
   always_comb begin
      logic [1:0] idx;
      logic       found;
      winner = last_owner;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = last_owner + 2'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any_req       = |req;
   assign owner_release = done || !req[sel];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

   logic [7:0] hold_cnt;
   logic       hold_expired;

   assign hold_expired = (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= 2'd3;
         gnt        <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         tmo        <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               tmo <= 1'b0;
               if (any_req) begin
                  sel      <= winner;
                  gnt      <= 4'b0001 << winner;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (owner_release || hold_expired) begin
                  gnt        <= '0;
                  busy       <= 1'b0;
                  last_owner <= sel;
                  // The timeout is flagged only when it is the sole reason for the release.
                  tmo        <= !owner_release;
                  state      <= IDLE;
               end else begin
                  tmo      <= 1'b0;
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign tmo = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= 2'd3;
         gnt        <= '0;
         sel        <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel   <= winner;
                  gnt   <= 4'b0001 << winner;
                  busy  <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (owner_release) begin
                  gnt        <= '0;
                  busy       <= 1'b0;
                  last_owner <= sel;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed-vector bench for mux4_rr_arbiter. The arbiter is instantiated with
//   TIMEOUT=4. The expectations for the timeout scenario depend on ARB_TIMEOUT_EN.
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       tmo;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mux4_rr_arbiter #(.TIMEOUT(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .done (done),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy),
      .tmo  (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance past one rising edge. Outputs are sampled 1 time unit after that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
      check({tag, ".gnt"},  8'(gnt),  8'(g));
      check({tag, ".sel"},  8'(sel),  8'(s));
      check({tag, ".busy"}, 8'(busy), 8'(b));
      check({tag, ".tmo"},  8'(tmo),  8'(t));
   endtask

   initial begin
      logic [1:0] order [4];
      order = '{2'd1, 2'd2, 2'd3, 2'd0};

      rst = 1'b1; req = '0; done = 1'b0;
      tick(); tick();
      check_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Basic grant, then release and re-arbitration past requester 0.
      rst = 1'b0; req = 4'b0101;
      tick();
      check_state("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_state("dead_cycle", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      check_state("second_grant", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Full rotation with every requester active.
      rst = 1'b1; tick();
      rst = 1'b0; req = 4'b1111;
      tick();
      check_state("rr_start", 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         done = 1'b1; tick();
         check("rr_gap.gnt", 8'(gnt), 8'h00);
         done = 1'b0; tick();
         check("rr_gnt", 8'(gnt), 8'(4'b0001 << order[k]));
         check("rr_sel", 8'(sel), 8'(order[k]));
      end

      // Requester 0 owns the grant now. Advance to owner 2, then owner 2 withdraws its request.
      done = 1'b1; tick(); done = 1'b0; tick();
      check("to_owner1.gnt", 8'(gnt), 8'b0010);
      done = 1'b1; tick(); done = 1'b0; tick();
      check("to_owner2.gnt", 8'(gnt), 8'b0100);
      req = 4'b0110; tick();
      check_state("other_req_ignored", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b1011; tick();
      check_state("withdraw", 4'b0000, 2'd2, 1'b0, 1'b0);
      tick();
      check_state("after_withdraw", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Reset in the middle of a grant to requester 1.
      req = 4'b1111;
      done = 1'b1; tick(); done = 1'b0; tick();
      check("to_owner0.gnt", 8'(gnt), 8'b0001);
      done = 1'b1; tick(); done = 1'b0; tick();
      check_state("owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
      rst = 1'b1; tick();
      check_state("mid_grant_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0; req = 4'b1010; tick();
      check_state("post_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

      // done together with an empty request vector, then done while in IDLE.
      done = 1'b1; req = 4'b0000; tick();
      check_state("done_no_req", 4'b0000, 2'd1, 1'b0, 1'b0);
      done = 1'b0; tick();
      check_state("idle_hold", 4'b0000, 2'd1, 1'b0, 1'b0);
      done = 1'b1; tick(); done = 1'b0;
      check_state("idle_done", 4'b0000, 2'd1, 1'b0, 1'b0);

      // Grant held with no done: timeout behaviour (TIMEOUT=4).
      rst = 1'b1; tick();
      rst = 1'b0; req = 4'b0011; tick();
      check_state("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         check_state("hold_cn", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick();
`ifdef ARB_TIMEOUT_EN
      check_state("timeout_release", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      check_state("after_timeout", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
      check_state("no_timeout_a", 4'b0001, 2'd0, 1'b1, 1'b0);
      tick(); tick(); tick();
      check_state("no_timeout_b", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
- Grants the mux to one requester at a time and drives the mux select (a[1:0]) for that requester.
- Holds the grant until the owner releases it, then re-arbitrates fairly.
- Sits directly in front of the mux; `sel` connects to the mux select, `gnt` returns to the requesters.

Parameters:
- TIMEOUT, 8: maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request lines; bit i is requester i, level-sensitive.
- done  input  1  release strobe from the current owner; sampled only in GRANT.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- sel  output  2  mux select, registered; equals the index of the granted requester.
- busy  output  1  high while in GRANT.
- tmo  output  1  one-cycle pulse on forced release (timeout); constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset, applied when rst=1 at a clk edge:
  - gnt=0000, sel=00, busy=0, tmo=0.
  - last-owner pointer=3, so requester 0 has top priority after reset.
  - State=IDLE.
  - Reset wins over every other event, including mid-grant; the grant is dropped at that same edge.
- States: IDLE, GRANT. All outputs are registered (no combinational path from req to gnt).
- IDLE:
  - If req==0000, stay in IDLE with gnt=0000 and busy=0. sel holds its last value.
  - Otherwise, search in order last+1, last+2, last+3, last (mod 4). The first set req bit is the winner w.
  - At the next edge: sel=w, gnt=1<<w, busy=1, state=GRANT.
  - Latency: req asserted before edge N gives gnt at edge N+1.
- GRANT:
  - Release condition: done=1, OR req[sel]=0 (owner withdrew its request), OR timeout (see Optional Feature).
  - On release, at the next edge: gnt=0000, busy=0, last=sel, state=IDLE. sel keeps its value.
  - Always one dead cycle with gnt=0000 between consecutive grants. The minimum grant-to-grant period is therefore 2 cycles.
  - Without release: hold gnt and sel unchanged. Changes on other req bits are ignored.
- Simultaneous events:
  - done together with new requests: release first; new requests are arbitrated in the following IDLE cycle.
  - done while in IDLE: ignored.
- Fairness: a continuously requesting requester is granted within at most 3 other grants.
- Single requester: with req=0001 held and done pulsed each grant, requester 0 is re-granted after every dead cycle.
- Invariant: gnt is always one-hot or zero; gnt!=0 exactly when busy=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches TIMEOUT-1 and no other release condition is present, the next edge forces a release with the normal release effects.
  - tmo=1 for exactly that one cycle (the first IDLE cycle).
  - A grant therefore lasts at most TIMEOUT cycles.
  - If done coincides with the timeout cycle, the release is normal and tmo stays 0.
- Not defined: no counter; grants last until done or request withdrawal; tmo tied to 0.

Test Plan:
- Reset, then req=0101 held -> gnt=0001, sel=00 one cycle after reset deasserts. Pulse done -> gnt=0000 one cycle, then gnt=0100, sel=10.
- req=1111 held, done pulsed every grant -> grant order 0,1,2,3,0, with one gnt=0000 cycle between each.
- Owner 2 granted, req drops to 1011 without done -> gnt=0000 next cycle, then gnt=1000, sel=11 (pointer advanced past 2).
- rst asserted while gnt=0010 -> gnt=0000, busy=0, sel=00 at that edge; after rst release with req=1010 -> gnt=0010.
- done and req=0000 in the same cycle during GRANT -> IDLE, gnt=0000 held, busy=0. A done pulse while in IDLE changes nothing.
- ARB_TIMEOUT_EN, TIMEOUT=4, req=0011 held, no done -> gnt=0001 for exactly 4 cycles, tmo=1 for one cycle, then gnt=0010. Same stimulus without the macro -> gnt=0001 held indefinitely and tmo=0.
